// File: rtl/spi_txn_scheduler.sv
// Round-robin burst scheduler in front of the SPI master datapath.
// Drives one active-low slave select per requester and moves bytes via SPDR.
module spi_txn_scheduler #(
   parameter int NREQ      = 4,
   parameter int SETUP_CYC = 2,
   parameter int GAP_CYC   = 3,
   parameter int TIMEOUT   = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [4*NREQ-1:0]       req_len,
   input  logic [8*NREQ-1:0]       req_tx_data,
   output logic [NREQ-1:0]         grant,
   output logic [NREQ-1:0]         tx_ack,
   output logic                    rx_valid,
   output logic [7:0]              rx_data,
   output logic [$clog2(NREQ)-1:0] rx_id,
   output logic                    err,
   output logic                    busy,
   output logic [NREQ-1:0]         ss_n,
   output logic                    spdr_we,
   output logic [7:0]              spdr_wdata,
   input  logic [7:0]              spdr_rdata,
   input  logic                    spif
);
   localparam int IDW = $clog2(NREQ);
   localparam int TW  = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE, SETUP, LOAD, WAIT, CAPTURE, GAP
   } state_t;

   state_t          state, state_d;
   logic [TW-1:0]   cnt, cnt_d;
   logic [3:0]      blen, blen_d;
   logic [IDW-1:0]  ptr, ptr_d, id_d, sel, idx, nxt;
   logic [NREQ-1:0] grant_d;
   logic [7:0]      rdat_d;
   logic            spif_q, rise, found, tmo;
   logic [3:0]      len_arr [NREQ];
   logic [7:0]      tx_arr  [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_slice
      assign len_arr[g] = req_len[4*g +: 4];
      assign tx_arr[g]  = req_tx_data[8*g +: 8];
   end

   // rx_id doubles as the granted index for the whole burst
   assign rise = spif & ~spif_q;
   assign tmo  = (cnt == TW'(TIMEOUT));
   assign nxt  = (rx_id == IDW'(NREQ - 1)) ? '0 : rx_id + IDW'(1);

   always_comb begin
      sel   = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = IDW'((int'(ptr) + k) % NREQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      blen_d  = blen;
      ptr_d   = ptr;
      grant_d = grant;
      id_d    = rx_id;
      rdat_d  = rx_data;
      unique case (state)
         IDLE: begin
            if (found) begin
               grant_d      = '0;
               grant_d[sel] = 1'b1;
               id_d         = sel;
               blen_d       = len_arr[sel];
               cnt_d        = '0;
               state_d      = SETUP;
            end
         end
         SETUP: begin
            if (cnt == TW'(SETUP_CYC - 1)) begin
               cnt_d   = '0;
               state_d = LOAD;
            end else begin
               cnt_d = cnt + TW'(1);
            end
         end
         LOAD: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (rise) begin
               rdat_d  = spdr_rdata;
               state_d = CAPTURE;
            end else if (tmo) begin
               grant_d = '0;
               ptr_d   = nxt;
               cnt_d   = '0;
               state_d = GAP;
            end else begin
               cnt_d = cnt + TW'(1);
            end
         end
         CAPTURE: begin
            if (blen == 4'd0) begin
               grant_d = '0;
               ptr_d   = nxt;
               cnt_d   = '0;
               state_d = GAP;
            end else begin
               blen_d  = blen - 4'd1;
               state_d = LOAD;
            end
         end
         GAP: begin
            if (cnt == TW'(GAP_CYC - 1)) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt + TW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         blen    <= '0;
         ptr     <= '0;
         grant   <= '0;
         rx_id   <= '0;
         rx_data <= '0;
         spif_q  <= 1'b0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         blen    <= blen_d;
         ptr     <= ptr_d;
         grant   <= grant_d;
         rx_id   <= id_d;
         rx_data <= rdat_d;
         spif_q  <= spif;
      end
   end

   assign busy       = (state != IDLE);
   assign spdr_we    = (state == LOAD);
   assign tx_ack     = spdr_we ? grant : '0;
   assign spdr_wdata = spdr_we ? tx_arr[rx_id] : '0;
   assign rx_valid   = (state == CAPTURE);
   assign err        = (state == WAIT) && !rise && tmo;
   assign ss_n       = ~grant;

endmodule
